// File: rtl/i2c_bus_pkg.sv
// i2c_bus_pkg: shared types and limits for the open-drain I2C bus model.
//   line_state_e : logical level of a resolved bus line
//   bus_event_t  : START / repeated START / STOP event bundle
//   MAX_AGENTS   : upper bound on drivers sharing the bus
//   MAX_FILT     : upper bound on the glitch-filter length (sizes its counter)
package i2c_bus_pkg;

   localparam int MAX_AGENTS = 16;
   localparam int MAX_FILT   = 15;

   typedef enum logic {
      LINE_LOW  = 1'b0,
      LINE_HIGH = 1'b1
   } line_state_e;

   typedef struct packed {
      logic start;
      logic rstart;
      logic stop;
   } bus_event_t;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: two-flop synchroniser followed by a stability filter for
// one bus line. The filtered copy only follows the synchronised line after
// FILT_LEN consecutive samples disagree with it.
//   clk, rst_n : clock, async active-low reset (all flops reset to line high)
//   line_in    : raw resolved line
//   line_sync  : synchronised line
//   line_filt  : glitch-filtered line
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_in,
   output logic line_sync,
   output logic line_filt
);
   import i2c_bus_pkg::*;

   localparam int CW = $clog2(MAX_FILT + 1);

   logic          sync_0;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_0     <= LINE_HIGH;
         line_sync  <= LINE_HIGH;
         line_filt  <= LINE_HIGH;
         stable_cnt <= '0;
      end else begin
         sync_0    <= line_in;
         line_sync <= sync_0;
         if (line_sync == line_filt) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CW'(FILT_LEN - 1)) begin
            // FILT_LEN-th disagreeing sample: accept the new level
            line_filt  <= line_sync;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/i2c_bus_resolver.sv
// i2c_bus_resolver: N-agent open-drain I2C bus model.
//   clk, rst_n          : clock, async active-low reset
//   scl_oe/scl_out      : per-agent SCL enable/value (oe=1,out=0 pulls low)
//   sda_oe/sda_out      : per-agent SDA enable/value
//   tx_active           : agent is sending data/address bits on SDA
//   arb_clr             : per-agent clear of arb_lost
//   scl_in/sda_in       : combinational wired-AND of the drivers
//   scl_filt/sda_filt   : synchronised, glitch-filtered lines
//   start_det/rstart_det/stop_det : registered one-cycle bus event pulses
//   bus_busy            : bus owned between START and STOP/idle timeout
//   arb_lost            : sticky per-agent arbitration loss
//   od_violation        : agent drove a line high while it was resolved low
module i2c_bus_resolver #(
   parameter int NUM_AGENTS      = 2,
   parameter int FILT_LEN        = 3,
   parameter int BUS_FREE_CYCLES = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_AGENTS-1:0] scl_oe,
   input  logic [NUM_AGENTS-1:0] scl_out,
   input  logic [NUM_AGENTS-1:0] sda_oe,
   input  logic [NUM_AGENTS-1:0] sda_out,
   input  logic [NUM_AGENTS-1:0] tx_active,
   input  logic [NUM_AGENTS-1:0] arb_clr,
   output logic                  scl_in,
   output logic                  sda_in,
   output logic                  scl_filt,
   output logic                  sda_filt,
   output logic                  start_det,
   output logic                  rstart_det,
   output logic                  stop_det,
   output logic                  bus_busy,
   output logic [NUM_AGENTS-1:0] arb_lost,
   output logic [NUM_AGENTS-1:0] od_violation
);
   import i2c_bus_pkg::*;

   localparam int FCW = $clog2(BUS_FREE_CYCLES);

   logic                  scl_sync, sda_sync;
   logic                  scl_filt_q, sda_filt_q, scl_sync_q;
   logic [FCW-1:0]        free_cnt;
   logic                  both_high, free_hit, scl_rise;
   logic [NUM_AGENTS-1:0] sda_release, rel_d1, rel_d2, tx_d1, tx_d2, arb_set;
   bus_event_t            evt_c;

   // Any enabled driver with out=0 pulls the line low; oe=1,out=1 is a release.
   assign scl_in = ~|(scl_oe & ~scl_out);
   assign sda_in = ~|(sda_oe & ~sda_out);

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk       (clk),
      .rst_n     (rst_n),
      .line_in   (scl_in),
      .line_sync (scl_sync),
      .line_filt (scl_filt)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk       (clk),
      .rst_n     (rst_n),
      .line_in   (sda_in),
      .line_sync (sda_sync),
      .line_filt (sda_filt)
   );

   // SCL must be high on both sides of the SDA edge, so simultaneous
   // SCL/SDA changes never qualify as an event.
   always_comb begin
      evt_c        = '0;
      evt_c.start  = scl_filt_q & scl_filt & sda_filt_q & ~sda_filt;
      evt_c.stop   = scl_filt_q & scl_filt & ~sda_filt_q & sda_filt;
      evt_c.rstart = evt_c.start & bus_busy;
   end

   assign both_high   = scl_filt & sda_filt;
   assign free_hit    = both_high && (free_cnt == FCW'(BUS_FREE_CYCLES - 1));
   assign sda_release = ~(sda_oe & ~sda_out);
   assign scl_rise    = scl_sync & ~scl_sync_q;
   // Intent and tx_active are delayed two cycles so they line up with sda_sync.
   assign arb_set     = {NUM_AGENTS{scl_rise & bus_busy & ~sda_sync}} & tx_d2 & rel_d2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_filt_q   <= LINE_HIGH;
         sda_filt_q   <= LINE_HIGH;
         scl_sync_q   <= LINE_HIGH;
         start_det    <= 1'b0;
         rstart_det   <= 1'b0;
         stop_det     <= 1'b0;
         bus_busy     <= 1'b0;
         free_cnt     <= '0;
         rel_d1       <= '1;
         rel_d2       <= '1;
         tx_d1        <= '0;
         tx_d2        <= '0;
         arb_lost     <= '0;
         od_violation <= '0;
      end else begin
         scl_filt_q <= scl_filt;
         sda_filt_q <= sda_filt;
         scl_sync_q <= scl_sync;
         start_det  <= evt_c.start;
         rstart_det <= evt_c.rstart;
         stop_det   <= evt_c.stop;

         // free_cnt saturates at the terminal value while the bus stays idle
         if (!both_high || evt_c.start)
            free_cnt <= '0;
         else if (!free_hit)
            free_cnt <= free_cnt + FCW'(1);

         if (evt_c.start)
            bus_busy <= 1'b1;
         else if (evt_c.stop || free_hit)
            bus_busy <= 1'b0;

         rel_d1 <= sda_release;
         rel_d2 <= rel_d1;
         tx_d1  <= tx_active;
         tx_d2  <= tx_d1;

         // a new loss wins over a clear arriving in the same cycle
         arb_lost <= arb_set | (arb_lost & ~arb_clr & ~{NUM_AGENTS{stop_det}});

         od_violation <= (scl_oe & scl_out & {NUM_AGENTS{~scl_in}}) |
                         (sda_oe & sda_out & {NUM_AGENTS{~sda_in}});
      end
   end

endmodule

// File: tb/tb_i2c_bus_resolver.sv
// tb_i2c_bus_resolver: directed bus scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural bus model.
module tb_i2c_bus_resolver;

   localparam int N   = 2;
   localparam int F   = 3;
   localparam int BFC = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] scl_oe, scl_out, sda_oe, sda_out, tx_active, arb_clr;
   logic         scl_in, sda_in, scl_filt, sda_filt;
   logic         start_det, rstart_det, stop_det, bus_busy;
   logic [N-1:0] arb_lost, od_violation;

   always #5 clk = ~clk;

   i2c_bus_resolver #(
      .NUM_AGENTS      (N),
      .FILT_LEN        (F),
      .BUS_FREE_CYCLES (BFC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .scl_oe       (scl_oe),
      .scl_out      (scl_out),
      .sda_oe       (sda_oe),
      .sda_out      (sda_out),
      .tx_active    (tx_active),
      .arb_clr      (arb_clr),
      .scl_in       (scl_in),
      .sda_in       (sda_in),
      .scl_filt     (scl_filt),
      .sda_filt     (sda_filt),
      .start_det    (start_det),
      .rstart_det   (rstart_det),
      .stop_det     (stop_det),
      .bus_busy     (bus_busy),
      .arb_lost     (arb_lost),
      .od_violation (od_violation)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // staged drive values, applied to the DUT at the next falling edge
   logic [N-1:0] d_scl_oe, d_scl_out, d_sda_oe, d_sda_out, d_tx, d_arb_clr;

   // behavioural model state (values as seen after the most recent clock edge)
   logic         m_s1_scl, m_sync_scl, m_psync_scl, m_filt_scl, m_pfilt_scl;
   logic         m_s1_sda, m_sync_sda, m_filt_sda, m_pfilt_sda;
   logic         q_scl[$];
   logic         q_sda[$];
   logic         m_start, m_rstart, m_stop, m_busy;
   int           m_run;
   logic [N-1:0] m_tx1, m_tx2, m_rel1, m_rel2, m_arb, m_od;

   // observation counters for directed scenarios
   int   mon_start, mon_rstart, mon_stop, mon_od1, first_start;
   logic min_sda_filt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic logic resolve(input logic [N-1:0] oe, input logic [N-1:0] v);
      logic r;
      r = 1'b1;
      for (int i = 0; i < N; i++)
         if (oe[i] && !v[i]) r = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      m_s1_scl = 1'b1; m_sync_scl = 1'b1; m_psync_scl = 1'b1;
      m_filt_scl = 1'b1; m_pfilt_scl = 1'b1;
      m_s1_sda = 1'b1; m_sync_sda = 1'b1;
      m_filt_sda = 1'b1; m_pfilt_sda = 1'b1;
      q_scl.delete(); q_sda.delete();
      m_start = 1'b0; m_rstart = 1'b0; m_stop = 1'b0; m_busy = 1'b0;
      m_run = 0;
      m_tx1 = '0; m_tx2 = '0; m_rel1 = '1; m_rel2 = '1;
      m_arb = '0; m_od = '0;
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_step();
      logic         res_scl, res_sda, start_c, stop_c, rise, both, flip, fs_n, fd_n;
      logic [N-1:0] arb_n, od_n;
      int           run_n;
      res_scl = resolve(scl_oe, scl_out);
      res_sda = resolve(sda_oe, sda_out);
      start_c = m_pfilt_sda && !m_filt_sda && m_pfilt_scl && m_filt_scl;
      stop_c  = !m_pfilt_sda && m_filt_sda && m_pfilt_scl && m_filt_scl;
      both    = m_filt_scl && m_filt_sda;
      run_n   = both ? m_run + 1 : 0;
      rise    = m_sync_scl && !m_psync_scl;
      for (int i = 0; i < N; i++) begin
         arb_n[i] = (rise && m_busy && m_tx2[i] && m_rel2[i] && !m_sync_sda) ||
                    (m_arb[i] && !arb_clr[i] && !m_stop);
         od_n[i]  = (scl_oe[i] && scl_out[i] && !res_scl) ||
                    (sda_oe[i] && sda_out[i] && !res_sda);
      end
      // filtered line follows once the last F synchronised samples all disagree
      q_scl.push_back(m_sync_scl);
      if (q_scl.size() > F) void'(q_scl.pop_front());
      q_sda.push_back(m_sync_sda);
      if (q_sda.size() > F) void'(q_sda.pop_front());
      fs_n = m_filt_scl;
      if (q_scl.size() == F) begin
         flip = 1'b1;
         foreach (q_scl[j]) if (q_scl[j] == m_filt_scl) flip = 1'b0;
         if (flip) fs_n = !m_filt_scl;
      end
      fd_n = m_filt_sda;
      if (q_sda.size() == F) begin
         flip = 1'b1;
         foreach (q_sda[j]) if (q_sda[j] == m_filt_sda) flip = 1'b0;
         if (flip) fd_n = !m_filt_sda;
      end
      m_rstart = start_c && m_busy;
      if (start_c)          m_busy = 1'b1;
      else if (stop_c)      m_busy = 1'b0;
      else if (run_n >= BFC) m_busy = 1'b0;
      m_start = start_c;
      m_stop  = stop_c;
      m_run   = run_n;
      m_arb   = arb_n;
      m_od    = od_n;
      m_pfilt_scl = m_filt_scl; m_filt_scl = fs_n;
      m_pfilt_sda = m_filt_sda; m_filt_sda = fd_n;
      m_psync_scl = m_sync_scl;
      m_sync_scl  = m_s1_scl; m_s1_scl = res_scl;
      m_sync_sda  = m_s1_sda; m_s1_sda = res_sda;
      m_tx2 = m_tx1; m_tx1 = tx_active;
      m_rel2 = m_rel1; m_rel1 = ~(sda_oe & ~sda_out);
   endtask

   task automatic compare_all();
      check_eq("scl_filt", 32'(scl_filt), 32'(m_filt_scl));
      check_eq("sda_filt", 32'(sda_filt), 32'(m_filt_sda));
      check_eq("start_det", 32'(start_det), 32'(m_start));
      check_eq("rstart_det", 32'(rstart_det), 32'(m_rstart));
      check_eq("stop_det", 32'(stop_det), 32'(m_stop));
      check_eq("bus_busy", 32'(bus_busy), 32'(m_busy));
      check_eq("arb_lost", 32'(arb_lost), 32'(m_arb));
      check_eq("od_violation", 32'(od_violation), 32'(m_od));
      if (start_det) begin
         mon_start++;
         if (first_start < 0) first_start = cyc;
      end
      if (rstart_det) mon_rstart++;
      if (stop_det) mon_stop++;
      if (od_violation[1]) mon_od1++;
      if (!sda_filt) min_sda_filt = 1'b0;
   endtask

   task automatic clear_mon();
      mon_start = 0; mon_rstart = 0; mon_stop = 0; mon_od1 = 0;
      first_start = -1; min_sda_filt = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
         compare_all();
         scl_oe = d_scl_oe; scl_out = d_scl_out;
         sda_oe = d_sda_oe; sda_out = d_sda_out;
         tx_active = d_tx; arb_clr = d_arb_clr;
         #1;
         check_eq("scl_in", 32'(scl_in), 32'(resolve(scl_oe, scl_out)));
         check_eq("sda_in", 32'(sda_in), 32'(resolve(sda_oe, sda_out)));
         model_step();
      end
   endtask

   // Called just after a falling edge; reset asserts and releases before the next rising edge.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_scl_filt", 32'(scl_filt), 32'd1);
      check_eq("rst_sda_filt", 32'(sda_filt), 32'd1);
      check_eq("rst_pulses", {29'd0, start_det, rstart_det, stop_det}, 32'd0);
      check_eq("rst_bus_busy", 32'(bus_busy), 32'd0);
      check_eq("rst_arb_lost", 32'(arb_lost), 32'd0);
      check_eq("rst_od_violation", 32'(od_violation), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
      model_step();
   endtask

   task automatic set_drive(input logic [N-1:0] so, input logic [N-1:0] sv,
                            input logic [N-1:0] dao, input logic [N-1:0] dav,
                            input logic [N-1:0] tx);
      d_scl_oe = so; d_scl_out = sv; d_sda_oe = dao; d_sda_out = dav; d_tx = tx;
   endtask

   initial begin
      int base;
      int hold;
      #2_000_000;
      $display("FAIL watchdog: observed no completion, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int base;
      int hold;
      set_drive('0, '0, '0, '0, '0);
      d_arb_clr = '0;
      scl_oe = '0; scl_out = '0; sda_oe = '0; sda_out = '0;
      tx_active = '0; arb_clr = '0;
      clear_mon();
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      do_reset();

      // idle bus, everyone released
      run(10);
      check_eq("idle_scl_in", 32'(scl_in), 32'd1);
      check_eq("idle_sda_in", 32'(sda_in), 32'd1);
      check_eq("idle_busy", 32'(bus_busy), 32'd0);

      // START then STOP by agent0
      clear_mon();
      base = cyc + 1;
      set_drive('0, '0, 2'b01, 2'b00, '0);
      run(10);
      check_eq("start_latency", 32'(first_start - base), 32'(3 + F));
      check_eq("busy_after_start", 32'(bus_busy), 32'd1);
      clear_mon();
      set_drive('0, '0, '0, '0, '0);
      run(10);
      check_eq("stop_seen", 32'(mon_stop), 32'd1);
      check_eq("busy_after_stop", 32'(bus_busy), 32'd0);

      // short glitch is suppressed, FILT_LEN-long one is not
      clear_mon();
      set_drive('0, '0, 2'b01, 2'b00, '0);
      run(F - 1);
      set_drive('0, '0, '0, '0, '0);
      run(10);
      check_eq("glitch_no_start", 32'(mon_start), 32'd0);
      check_eq("glitch_sda_filt", 32'(min_sda_filt), 32'd1);
      clear_mon();
      set_drive('0, '0, 2'b01, 2'b00, '0);
      run(F);
      set_drive('0, '0, '0, '0, '0);
      run(10);
      check_eq("glitch_start", 32'(mon_start), 32'd1);

      // arbitration: agent1 releases SDA while agent0 holds it low
      set_drive('0, '0, 2'b01, 2'b00, '0);
      run(10);
      set_drive(2'b01, 2'b00, 2'b01, 2'b00, 2'b11);
      run(6);
      set_drive('0, '0, 2'b01, 2'b00, 2'b11);
      run(6);
      check_eq("arb_lost_set", 32'(arb_lost), 32'h2);
      d_arb_clr = 2'b10;
      run(1);
      d_arb_clr = '0;
      run(3);
      check_eq("arb_lost_clr", 32'(arb_lost), 32'h0);

      // repeated START on a busy bus
      set_drive(2'b01, 2'b00, 2'b01, 2'b00, '0);
      run(6);
      set_drive(2'b01, 2'b00, '0, '0, '0);
      run(6);
      set_drive('0, '0, '0, '0, '0);
      run(6);
      clear_mon();
      set_drive('0, '0, 2'b01, 2'b00, '0);
      run(10);
      check_eq("rstart_seen", 32'(mon_rstart), 32'd1);
      check_eq("rstart_start", 32'(mon_start), 32'd1);
      check_eq("rstart_busy", 32'(bus_busy), 32'd1);

      // bus-free timeout without STOP
      set_drive(2'b01, 2'b00, 2'b01, 2'b00, '0);
      run(6);
      set_drive(2'b01, 2'b00, '0, '0, '0);
      run(6);
      clear_mon();
      set_drive('0, '0, '0, '0, '0);
      run(20);
      check_eq("timeout_still_busy", 32'(bus_busy), 32'd1);
      run(25);
      check_eq("timeout_busy_clr", 32'(bus_busy), 32'd0);
      check_eq("timeout_no_stop", 32'(mon_stop), 32'd0);

      // open-drain violation: agent1 drives SDA high against agent0
      clear_mon();
      set_drive('0, '0, 2'b11, 2'b10, '0);
      run(1);
      check_eq("od_sda_in", 32'(sda_in), 32'd0);
      run(3);
      check_eq("od_pulse_seen", 32'(mon_od1 > 0), 32'd1);

      // reset in the middle of a byte
      set_drive(2'b01, 2'b00, 2'b01, 2'b00, 2'b11);
      run(3);
      check_eq("busy_before_rst", 32'(bus_busy), 32'd1);
      do_reset();
      set_drive('0, '0, '0, '0, '0);
      run(10);
      check_eq("busy_after_rst", 32'(bus_busy), 32'd0);

      // randomized traffic
      hold = 0;
      for (int k = 0; k < 2500; k++) begin
         if (hold == 0) begin
            d_scl_oe  = N'($urandom);
            d_scl_out = N'($urandom);
            d_sda_oe  = N'($urandom);
            d_sda_out = N'($urandom);
            d_tx      = N'($urandom);
            hold      = $urandom_range(1, 7);
         end
         d_arb_clr = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
         run(1);
         hold--;
         if ($urandom_range(0, 499) == 0) do_reset();
      end
      d_arb_clr = '0;
      set_drive('0, '0, '0, '0, '0);
      run(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
